validator_ingress_arbiter: RTL

- Shares the single validator transaction input between N_REQ independent transaction sources.
- Validator input has no backpressure, so this block is its only sequencer. It accepts at most one transaction per issue slot using round-robin arbitration and enforces a programmable minimum idle gap between issues.
- Drives the validator's i_valid and i_transcation from registers. Also exports the winning source ID and an issue counter for status.

---
 rtl/validator_pkg.sv | 20 ++
 rtl/validator_ingress_arbiter_rr.sv | 39 +++
 rtl/validator_ingress_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/validator_pkg.sv
// Shared types and sizing helpers for the validator ingress path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package validator_pkg;

   localparam int DATA_W = 128;

   typedef logic [DATA_W-1:0] trans_t;

   typedef enum logic {
      IDLE = 1'b0,
      GAP  = 1'b1
   } arb_state_e;

   // Index width that never collapses to zero bits, even for a single requester.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/validator_ingress_arbiter_rr.sv
// Round-robin picker: first asserted request at or after ptr, wrapping modulo N.
// Latency: purely combinational, zero cycles.
// Backpressure: none; gnt is all-zero when no request is asserted.
module rr_arbiter
   import validator_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx
);

   logic [2*N-1:0] w_rot2;
   logic [N-1:0]   w_rot;
   int             w_sel;
   int             w_sum;

   // Rotate requests so bit 0 is the pointer slot, pick the lowest set bit, un-rotate.
   always_comb begin
      w_rot2 = {i_req, i_req} >> i_ptr;
      w_rot  = w_rot2[N-1:0];
      w_sel  = 0;
      for (int j = N - 1; j >= 0; j--) begin
         if (w_rot[j]) begin
            w_sel = j;
         end
      end
      w_sum = int'(i_ptr) + w_sel;
      if (w_sum >= N) begin
         w_sum = w_sum - N;
      end
      o_idx = IW'(w_sum);
      o_gnt = (|i_req) ? (N'(1) << o_idx) : '0;
   end

endmodule

// File: rtl/validator_ingress_arbiter.sv
// Round-robin sequencer sharing one validator input among N_REQ sources, with an idle gap after each issue.
// Latency: accept at edge t gives a one-cycle o_valid beat in cycle t+1.
// Backpressure: req_ready withheld while disabled, in reset or counting the post-issue gap.
module validator_ingress_arbiter #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = validator_pkg::DATA_W,
   parameter int GAP_W  = 4,
   parameter int CNT_W  = 32,
   parameter int SRC_W  = validator_pkg::idx_w(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cfg_en,
   input  logic [GAP_W-1:0]        cfg_gap,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        req_ready,
   output logic                    o_valid,
   output logic [DATA_W-1:0]       o_transaction,
   output logic [SRC_W-1:0]        o_src,
   output logic [CNT_W-1:0]        o_issue_cnt,
   output logic                    o_busy
);
   import validator_pkg::*;

   arb_state_e        r_state;
   arb_state_e        w_state_nxt;
   logic [GAP_W-1:0]  r_gap_cnt;
   logic [GAP_W-1:0]  w_gap_nxt;
   logic [SRC_W-1:0]  r_ptr;
   logic [SRC_W-1:0]  w_ptr_nxt;
   logic [SRC_W-1:0]  w_idx;
   logic [N_REQ-1:0]  w_gnt;
   logic              w_grant;
   logic [DATA_W-1:0] w_win_dat;
   logic              r_valid;
   logic [DATA_W-1:0] r_trans;
   logic [SRC_W-1:0]  r_src;
   logic [CNT_W-1:0]  r_cnt;

   rr_arbiter #(
      .N  (N_REQ),
      .IW (SRC_W)
   ) u_rr (
      .i_req (req_valid),
      .i_ptr (r_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_idx)
   );

   // A grant needs reset released, enable set, a requester and the idle state.
   always_comb begin
      w_grant   = rst & cfg_en & (|req_valid) & (r_state == IDLE);
      req_ready = w_grant ? w_gnt : '0;
      w_ptr_nxt = (w_idx == SRC_W'(N_REQ - 1)) ? '0 : (w_idx + SRC_W'(1));
   end

   // Steer the winning source's slice; the grant is one-hot so an OR-mux suffices.
   always_comb begin
      w_win_dat = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_gnt[i]) begin
            w_win_dat = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Next state: cfg_gap is captured only on the issue cycle, then counts down to 1.
   always_comb begin
      w_state_nxt = r_state;
      w_gap_nxt   = r_gap_cnt;
      case (r_state)
         IDLE: begin
            if (w_grant && (cfg_gap != '0)) begin
               w_state_nxt = GAP;
               w_gap_nxt   = cfg_gap;
            end
         end
         GAP: begin
            w_gap_nxt = r_gap_cnt - GAP_W'(1);
            if (r_gap_cnt == GAP_W'(1)) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State, pointer and output registers; reset drops any pending beat.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_gap_cnt <= '0;
         r_ptr     <= '0;
         r_valid   <= 1'b0;
         r_trans   <= '0;
         r_src     <= '0;
         r_cnt     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_gap_cnt <= w_gap_nxt;
         r_valid   <= w_grant;
         if (w_grant) begin
            r_ptr   <= w_ptr_nxt;
            r_trans <= w_win_dat;
            r_src   <= w_idx;
            r_cnt   <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_valid       = r_valid;
   assign o_transaction = r_trans;
   assign o_src         = r_src;
   assign o_issue_cnt   = r_cnt;
   assign o_busy        = (r_state == GAP);

endmodule
